// File: rtl/fp_result_uart_tx.sv
// Serialises a 5-byte result packet {HDR_TAG,op}, result[31:24..7:0] over an 8N1 UART line.
// Handshake: start is a one-cycle request; it is accepted only while busy=0, and tx_done pulses once per packet.
module fp_result_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [5:0]  HDR_TAG      = 6'b101000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] result,
  input  logic [1:0]  op,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_cnt;
  logic [39:0] shift_reg;
  logic        baud_last;
  logic [7:0]  cur_byte;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign cur_byte  = shift_reg[39:32];
  assign state_dbg = state;

  // tx is registered: each transition edge loads the level for the coming bit period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 3'd0;
      shift_reg <= 40'd0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        baud_cnt <= 16'd0;
        if (start) begin
          shift_reg <= {HDR_TAG, op, result};
          bit_cnt   <= 3'd0;
          byte_cnt  <= 3'd0;
          busy      <= 1'b1;
          tx        <= 1'b0;
          state     <= START_BIT;
        end
      end else if (!baud_last) begin
        baud_cnt <= baud_cnt + 16'd1;
      end else begin
        baud_cnt <= 16'd0;
        case (state)
          START_BIT: begin
            bit_cnt <= 3'd0;
            tx      <= cur_byte[0];
            state   <= DATA_BITS;
          end
          DATA_BITS: begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              tx      <= 1'b1;
              state   <= STOP_BIT;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= cur_byte[bit_cnt + 3'd1];
            end
          end
          STOP_BIT: begin
            if (byte_cnt == 3'd4) begin
              byte_cnt  <= 3'd0;
              shift_reg <= 40'd0;
              busy      <= 1'b0;
              tx_done   <= 1'b1;
              tx        <= 1'b1;
              state     <= IDLE;
            end else begin
              // Next byte moves into the top of the shift register with no idle gap.
              byte_cnt  <= byte_cnt + 3'd1;
              shift_reg <= {shift_reg[31:0], 8'd0};
              tx        <= 1'b0;
              state     <= START_BIT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/fp_result_uart_tx.md
FP_RESULT_UART_TX -- requirements
Module: fp_result_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter HDR_TAG, default 6'b101000, upper six bits of the header byte.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 start  input  1  one-cycle request to send one result packet.
REQ-006 result  input  32  IEEE-754 single-precision result word; sampled when start is accepted.
REQ-007 op  input  2  opcode that produced result (00 add, 01 sub, 10 mul, 11 unknown); sampled with result.
REQ-008 tx  output  1  UART serial line, 8N1, idle high.
REQ-009 busy  output  1  high while a packet is in flight.
REQ-010 tx_done  output  1  one-cycle pulse at packet completion.

Function
REQ-011 Packet is 5 bytes in this order: header {HDR_TAG, op}, result[31:24], result[23:16], result[15:8], result[7:0].
REQ-012 Each byte is framed as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); each bit holds tx for exactly CLKS_PER_BIT cycles.
REQ-013 FSM states are IDLE, START_BIT, DATA_BITS, STOP_BIT; reset state is IDLE.
REQ-014 Start acceptance:
  - start=1 in IDLE latches result and op into a 40-bit shift register.
  - The same edge sets busy=1 and enters START_BIT.
  - tx goes low on the following cycle (registered output).
REQ-015 START_BIT -> DATA_BITS after CLKS_PER_BIT cycles; DATA_BITS -> STOP_BIT after 8 bits, with a 3-bit bit counter; STOP_BIT -> START_BIT for the next byte, with a 3-bit byte counter 0..4.
REQ-016 After the stop bit of byte 4: the FSM returns to IDLE, busy drops to 0 and tx_done=1, all for exactly one cycle, on the same edge.
REQ-017 Total packet duration is 50*CLKS_PER_BIT cycles from the first tx-low cycle to the tx_done cycle; there are no idle gaps between bytes.
REQ-018 start while busy=1 is ignored; the latched data and timing are unaffected and nothing is queued.
REQ-019 start in the tx_done cycle is accepted, because busy=0; this gives back-to-back packets with no idle bit between them.
REQ-020 The baud counter counts 0..CLKS_PER_BIT-1 and wraps; it is held at 0 in IDLE.
REQ-021 result and op changing after acceptance shall not alter the packet in flight.

Reset
REQ-022 reset=0 forces, asynchronously: tx=1, busy=0, tx_done=0, FSM=IDLE, and all counters and the shift register to 0.
REQ-023 Reset mid-packet aborts the transfer; no tx_done is generated for the aborted packet.
REQ-024 The first start after reset release is accepted normally on the next rising edge.

Verification (CLKS_PER_BIT=4, so a packet lasts 200 cycles)
REQ-025 start, result=0x41000000, op=00 -> bytes A0 41 00 00 00 decoded on tx; tx_done 200 cycles after the first low bit; busy high throughout.
REQ-026 start, result=0x40000000, op=01 -> bytes A1 40 00 00 00; each stop bit high for 4 cycles.
REQ-027 start, result=0x7FC00000, op=10, with a second start at cycle 50 carrying result=0x12345678 -> only A2 7F C0 00 00 is sent; exactly one tx_done.
REQ-028 reset pulsed low at cycle 70 of a packet -> tx=1 and busy=0 immediately, no tx_done; a new start with result=0x7F800000, op=00 afterwards -> A0 7F 80 00 00.
REQ-029 start asserted in the tx_done cycle with result=0xFF800000, op=01 -> second packet A1 FF 80 00 00 whose start bit directly follows the previous stop bit.
REQ-030 Idle check: with no start for 100 cycles after reset -> tx=1, busy=0, tx_done=0 throughout.
